tmds_frame_gen: RTL and testbench
=================================

// Module: tmds_frame_gen
// PURPOSE
//  DVI/HDMI-style TMDS source: video timing counters, 8b/10b TMDS data encoding, control tokens,
//  video preamble and guard bands. Emits a 30-bit parallel word per pixel clock for the TX serialisers.
//  Transmit-side counterpart of the capture path's token decoder (CTLTKN0-3, guard-band START0).
//  Used for loopback test patterns and for driving the TX port from a pixel source.
// PARAMETERS
//  H_ACTIVE 640 | H_FP 16 | H_SYNC 96 | H_BP 48   horizontal pixels (H_BP >= 10)
//  V_ACTIVE 480 | V_FP 10 | V_SYNC 2  | V_BP 33   vertical lines
//  HS_POL 1'b0 / VS_POL 1'b0   level driven on hsync/vsync while in the sync region
// PORTS
//  clk        in   1   pixel clock
//  rst        in   1   synchronous, active-high reset
//  enable     in   1   run timing; sampled only while idle or on the last cycle of a frame
//  pix_req    out  1   high in each active-pixel cycle; pix_rgb is consumed on that same edge
//  pix_rgb    in   24  {R[23:16],G[15:8],B[7:0]}; valid whenever pix_req=1 (first-word-fallthrough source)
//  data       out  30  {ch2(R)[29:20], ch1(G)[19:10], ch0(B)[9:0]} TMDS symbols
//  valid      out  1   data carries a live timing stream (0 while idle)
//  hsync_o    out  1   hsync aligned with data
//  vsync_o    out  1   vsync aligned with data
//  frame_start out 1   1-cycle pulse with the first active-pixel symbol of each frame
// BEHAVIOUR
//  Timing: hcnt 0..H_TOT-1 (H_TOT = sum of H_*), order ACTIVE, FP, SYNC, BP. vcnt 0..V_TOT-1, same order.
//   hsync = HS_POL when hcnt is in the SYNC region, else ~HS_POL. vsync = VS_POL for the whole line
//   when vcnt is in the SYNC region. vcnt advances when hcnt wraps.
//  States: IDLE (counters held) -> RUN when enable=1. Entry point is hcnt=0, vcnt=V_ACTIVE (start of
//   V_FP) so the first frame is complete. RUN -> IDLE only when enable=0 at hcnt=H_TOT-1, vcnt=V_TOT-1.
//   enable is ignored at all other times.
//  Period per cycle (active line = vcnt < V_ACTIVE):
//   VIDEO     hcnt < H_ACTIVE on an active line; pix_req=1.
//   PREAMBLE  hcnt in H_TOT-10..H_TOT-3, when the next line is active (vcnt < V_ACTIVE-1 or vcnt = V_TOT-1).
//             ch1 = CTLTKN1, ch2 = CTLTKN0.
//   GUARD     hcnt H_TOT-2, H_TOT-1 on the same lines. ch0 = 0x2CC, ch1 = 0x133, ch2 = 0x2CC.
//   CONTROL   all other cycles. ch1 = ch2 = CTLTKN0.
//   ch0 carries {vsync,hsync} in every non-GUARD, non-VIDEO cycle:
//    00 -> 0x354, 01 -> 0x0AB, 10 -> 0x154, 11 -> 0x2AB.
//  Encoding: DVI 1.0 TMDS per channel.
//   - q_m: XOR/XNOR choice from the popcount of the byte.
//   - Output: DC-balancing inversion driven by a signed 5-bit running disparity per channel.
//   - Disparity is cleared to 0 in every non-VIDEO cycle and on reset.
//  Latency: fixed 3 cycles from the timing decision to data/hsync_o/vsync_o/valid/frame_start. Control and
//   video paths are padded to the same depth. A pixel sampled with pix_req at edge N appears on data after
//   edge N+3.
//  Reset: data = 0x354D5354 ({3{CTLTKN0}}), hsync_o = ~HS_POL, vsync_o = ~VS_POL, valid = 0,
//   frame_start = 0, pix_req = 0. Pipeline is flushed, state = IDLE.
//   Reset mid-line aborts immediately. No partial-pixel handshake survives.
//  IDLE: outputs hold the reset values; valid drops 3 cycles after leaving RUN.
//  Boundary: hcnt and vcnt wrap in the same cycle at frame end. Preamble/guard on line V_TOT-1 precede
//   line 0. No preamble precedes the first blank line.
// TESTING (bench params H 4/2/2/12, V 2/1/1/1, HS_POL = VS_POL = 1 -> H_TOT = 20, V_TOT = 5)
//  1. Reset asserted -> data = 0x354D5354, valid = 0, pix_req = 0. Held for 10 cycles with enable = 0
//     -> unchanged.
//  2. enable=1, pix_rgb = 0x000000 -> per active line each channel emits 0x100, 0x3FF, 0x100, 0x3FF.
//     Disparity restarts every line.
//  3. Cycles before each active line:
//     - 8x {ch2 = 0x354, ch1 = 0x0AB, ch0 = 0x354}
//     - then 2x {0x2CC, 0x133, 0x2CC}
//     - then video.
//  4. Sync: hsync-only cycles -> ch0 = 0x0AB; vsync line outside hsync -> ch0 = 0x154;
//     both -> ch0 = 0x2AB. hsync_o/vsync_o match.
//  5. Incrementing pix_rgb source -> 8 pix_req per frame. Each symbol decodes to the pixel sampled 3 cycles
//     earlier. frame_start pulses once per 100 cycles.
//  6. Reset mid-video-line, and enable=0 mid-frame -> reset restarts from IDLE. enable=0 finishes the frame,
//     then valid = 0 and data = 0x354D5354.

Source files
------------

// File: rtl/tmds_frame_gen.sv
// TMDS source: video timing, DVI 8b/10b encoding, control tokens,
// video preamble and guard bands; one 30-bit symbol word per pixel clock.
module tmds_frame_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        pix_req,
    input  logic [23:0] pix_rgb,
    output logic [29:0] data,
    output logic        valid,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_start
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_PRE  = HW'(H_TOT - 10);
    localparam logic [HW-1:0] H_GRD  = HW'(H_TOT - 2);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_AM1  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [9:0] CTL0  = 10'h354;
    localparam logic [9:0] CTL1  = 10'h0AB;
    localparam logic [9:0] CTL2  = 10'h154;
    localparam logic [9:0] CTL3  = 10'h2AB;
    localparam logic [9:0] GB_RB = 10'h2CC;
    localparam logic [9:0] GB_G  = 10'h133;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [2:0] {P_IDLE, P_CTRL, P_PRE, P_GUARD, P_VIDEO} per_t;

    function automatic logic [3:0] f_pop8(input logic [7:0] b);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
        return n;
    endfunction

    function automatic logic [8:0] f_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       xnr;
        logic [8:0] q;
        n1   = f_pop8(d);
        xnr  = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++)
            q[i] = xnr ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~xnr;
        return q;
    endfunction

    // Returns {next disparity, symbol}; d is N1-N0 of q_m[7:0], always even.
    function automatic logic [14:0] f_enc(input logic [8:0] qm,
                                          input logic [3:0] n1,
                                          input logic signed [4:0] cnt);
        logic signed [4:0] d;
        logic signed [4:0] c;
        logic [9:0]        s;
        d = $signed({n1, 1'b0} - 5'd8);
        if (cnt == 5'sd0 || d == 5'sd0) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            c = qm[8] ? cnt + d : cnt - d;
        end else if ((cnt > 5'sd0 && d > 5'sd0) || (cnt < 5'sd0 && d < 5'sd0)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            c = cnt - d + (qm[8] ? 5'sd2 : 5'sd0);
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            c = cnt + d - (qm[8] ? 5'sd0 : 5'sd2);
        end
        return {c, s};
    endfunction

    function automatic logic [9:0] f_ctl(input logic vs, input logic hs);
        logic [9:0] t;
        unique case ({vs, hs})
            2'b00:   t = CTL0;
            2'b01:   t = CTL1;
            2'b10:   t = CTL2;
            default: t = CTL3;
        endcase
        return t;
    endfunction

    state_t          r_state, w_state_nx;
    logic [HW-1:0]   r_hcnt, w_hcnt_nx;
    logic [VW-1:0]   r_vcnt, w_vcnt_nx;
    logic            w_run, w_hlast, w_vlast, w_nxt_act;
    logic            w_vid, w_pre, w_grd, w_hs, w_vs;
    per_t            w_per;

    per_t            r1_per, r2_per, r3_per;
    logic            r1_hs, r2_hs, r3_hs, r1_vs, r2_vs, r3_vs;
    logic            r1_val, r2_val, r3_val, r1_fs, r2_fs, r3_fs;
    logic [23:0]     r1_rgb;
    logic [8:0]      r2_qm [3];
    logic [8:0]      r3_qm [3];
    logic [3:0]      r3_n1 [3];
    logic signed [4:0] r_cnt [3];
    logic [14:0]     w_enc [3];
    logic [29:0]     w_data;

    assign w_run     = (r_state == S_RUN);
    assign w_hlast   = (r_hcnt == H_LAST);
    assign w_vlast   = (r_vcnt == V_LAST);
    assign w_nxt_act = (r_vcnt < V_AM1) || w_vlast;
    assign w_vid     = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
    assign w_pre     = w_nxt_act && (r_hcnt >= H_PRE) && (r_hcnt < H_GRD);
    assign w_grd     = w_nxt_act && (r_hcnt >= H_GRD);
    assign w_hs      = (w_run && r_hcnt >= H_SS && r_hcnt < H_SE) ? HS_POL : ~HS_POL;
    assign w_vs      = (w_run && r_vcnt >= V_SS && r_vcnt < V_SE) ? VS_POL : ~VS_POL;
    assign pix_req   = w_run && w_vid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_vcnt  <= V_ACT;
        end else begin
            r_state <= w_state_nx;
            r_hcnt  <= w_hcnt_nx;
            r_vcnt  <= w_vcnt_nx;
        end
    end

    // Leaving RUN parks the counters at the start of V_FP for the next entry.
    always_comb begin
        w_state_nx = r_state;
        w_hcnt_nx  = r_hcnt;
        w_vcnt_nx  = r_vcnt;
        unique case (r_state)
            S_IDLE: if (enable) w_state_nx = S_RUN;
            S_RUN: begin
                if (!w_hlast) begin
                    w_hcnt_nx = r_hcnt + 1'b1;
                end else begin
                    w_hcnt_nx = '0;
                    if (!w_vlast) begin
                        w_vcnt_nx = r_vcnt + 1'b1;
                    end else if (enable) begin
                        w_vcnt_nx = '0;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_vcnt_nx  = V_ACT;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_per = P_CTRL;
        unique case (1'b1)
            !w_run:          w_per = P_IDLE;
            w_run && w_vid:  w_per = P_VIDEO;
            w_run && w_pre:  w_per = P_PRE;
            w_run && w_grd:  w_per = P_GUARD;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_per <= P_IDLE;  r2_per <= P_IDLE;  r3_per <= P_IDLE;
            r1_hs  <= ~HS_POL; r2_hs  <= ~HS_POL; r3_hs  <= ~HS_POL;
            r1_vs  <= ~VS_POL; r2_vs  <= ~VS_POL; r3_vs  <= ~VS_POL;
            r1_val <= 1'b0;    r2_val <= 1'b0;    r3_val <= 1'b0;
            r1_fs  <= 1'b0;    r2_fs  <= 1'b0;    r3_fs  <= 1'b0;
            r1_rgb <= '0;
            for (int c = 0; c < 3; c++) begin
                r2_qm[c] <= '0;
                r3_qm[c] <= '0;
                r3_n1[c] <= '0;
            end
        end else begin
            r1_per <= w_per;  r2_per <= r1_per; r3_per <= r2_per;
            r1_hs  <= w_hs;   r2_hs  <= r1_hs;  r3_hs  <= r2_hs;
            r1_vs  <= w_vs;   r2_vs  <= r1_vs;  r3_vs  <= r2_vs;
            r1_val <= w_run;  r2_val <= r1_val; r3_val <= r2_val;
            r1_fs  <= w_run && r_hcnt == '0 && r_vcnt == '0;
            r2_fs  <= r1_fs;  r3_fs  <= r2_fs;
            r1_rgb <= pix_req ? pix_rgb : '0;
            for (int c = 0; c < 3; c++) begin
                r2_qm[c] <= f_qm(r1_rgb[c*8 +: 8]);
                r3_qm[c] <= r2_qm[c];
                r3_n1[c] <= f_pop8(r2_qm[c][7:0]);
            end
        end
    end

    always_comb begin
        w_data = {3{CTL0}};
        for (int c = 0; c < 3; c++)
            w_enc[c] = f_enc(r3_qm[c], r3_n1[c], r_cnt[c]);
        unique case (r3_per)
            P_CTRL:  w_data = {CTL0, CTL0, f_ctl(r3_vs, r3_hs)};
            P_PRE:   w_data = {CTL0, CTL1, f_ctl(r3_vs, r3_hs)};
            P_GUARD: w_data = {GB_RB, GB_G, GB_RB};
            P_VIDEO: w_data = {w_enc[2][9:0], w_enc[1][9:0], w_enc[0][9:0]};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data        <= {3{CTL0}};
            valid       <= 1'b0;
            hsync_o     <= ~HS_POL;
            vsync_o     <= ~VS_POL;
            frame_start <= 1'b0;
            for (int c = 0; c < 3; c++) r_cnt[c] <= 5'sd0;
        end else begin
            data        <= w_data;
            valid       <= r3_val;
            hsync_o     <= r3_hs;
            vsync_o     <= r3_vs;
            frame_start <= r3_fs;
            for (int c = 0; c < 3; c++)
                r_cnt[c] <= (r3_per == P_VIDEO) ? $signed(w_enc[c][14:10]) : 5'sd0;
        end
    end
endmodule

// File: tb/tb_tmds_frame_gen.sv
// Bench for tmds_frame_gen: random pixels and enable checked against a
// frame-position reference model with TMDS encode/decode and 3-cycle delay.
module tb_tmds_frame_gen;
    localparam int HA = 4, HF = 2, HSY = 2, HB = 12;
    localparam int VA = 2, VF = 1, VSY = 1, VB = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int FT = HT * VT;
    localparam int ENTRY = VA * HT;
    localparam logic [29:0] IDLE_W = 30'h354D5354;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] pix_rgb = '0;
    logic        pix_req, valid, hsync_o, vsync_o, frame_start;
    logic [29:0] data;

    typedef struct {
        logic [29:0] data;
        logic        hs, vs, val, fs, vid;
        logic [23:0] rgb;
        int          px;
    } exp_t;

    exp_t q[$];
    int   m_disp[3];
    bit   m_run;
    int   m_pos;
    int   n_assert = 0;
    int   n_fail = 0;
    int   cnt_req, cnt_fs;
    bit   zero_phase;

    tmds_frame_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pix_req(pix_req),
        .pix_rgb(pix_rgb), .data(data), .valid(valid),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9:0] ctl_tok(input logic vs, input logic hs);
        case ({vs, hs})
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
        endcase
    endfunction

    function automatic logic [9:0] enc(input logic [7:0] d, input int ch);
        int n1d, n1q, n0q;
        bit xnr;
        logic [8:0] qm;
        logic [9:0] s;
        n1d = $countones(d);
        xnr = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = xnr ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xnr;
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (m_disp[ch] == 0 || n1q == n0q) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            m_disp[ch] += qm[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((m_disp[ch] > 0 && n1q > n0q) || (m_disp[ch] < 0 && n0q > n1q)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            m_disp[ch] += 2 * int'(qm[8]) + (n0q - n1q);
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            m_disp[ch] += -2 * int'(!qm[8]) + (n1q - n0q);
        end
        return s;
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] d, o;
        d = s[9] ? ~s[7:0] : s[7:0];
        o[0] = d[0];
        for (int i = 1; i < 8; i++)
            o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return o;
    endfunction

    function automatic exp_t idle_e();
        exp_t e;
        e.data = IDLE_W; e.hs = 1'b0; e.vs = 1'b0; e.val = 1'b0;
        e.fs = 1'b0; e.vid = 1'b0; e.rgb = '0; e.px = 0;
        return e;
    endfunction

    function automatic exp_t model_out(input logic [23:0] rgb);
        exp_t e;
        int h, v;
        bit nxt, pre, grd;
        e = idle_e();
        if (!m_run) begin
            for (int c = 0; c < 3; c++) m_disp[c] = 0;
            return e;
        end
        h = m_pos % HT;
        v = m_pos / HT;
        e.val = 1'b1;
        e.hs  = (h >= HA + HF && h < HA + HF + HSY);
        e.vs  = (v >= VA + VF && v < VA + VF + VSY);
        e.fs  = (m_pos == 0);
        e.vid = (v < VA && h < HA);
        e.px  = h;
        e.rgb = rgb;
        nxt = ((v + 1) % VT) < VA;
        pre = nxt && h >= HT - 10 && h <= HT - 3;
        grd = nxt && h >= HT - 2;
        if (e.vid) begin
            e.data = {enc(rgb[23:16], 2), enc(rgb[15:8], 1), enc(rgb[7:0], 0)};
        end else begin
            for (int c = 0; c < 3; c++) m_disp[c] = 0;
            if (grd)      e.data = {10'h2CC, 10'h133, 10'h2CC};
            else if (pre) e.data = {10'h354, 10'h0AB, ctl_tok(e.vs, e.hs)};
            else          e.data = {10'h354, 10'h354, ctl_tok(e.vs, e.hs)};
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic en, input logic [23:0] rgb);
        exp_t e, o;
        logic [9:0] zs;
        rst = r; enable = en; pix_rgb = rgb;
        #1;
        e = idle_e();
        if (!r) begin
            chk("pix_req", 32'(pix_req),
                32'(m_run && (m_pos / HT) < VA && (m_pos % HT) < HA));
            cnt_req += int'(pix_req);
            e = model_out(rgb);
        end
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            o = idle_e();
            repeat (3) q.push_back(o);
            m_run = 1'b0; m_pos = ENTRY;
            for (int c = 0; c < 3; c++) m_disp[c] = 0;
            chk("rst_pix_req", 32'(pix_req), 32'd0);
        end else begin
            q.push_back(e);
            o = q.pop_front();
            if (!m_run) begin
                if (en) m_run = 1'b1;
            end else if (m_pos == FT - 1) begin
                m_pos = 0;
                if (!en) begin m_run = 1'b0; m_pos = ENTRY; end
            end else begin
                m_pos++;
            end
        end
        chk("data", 32'(data), 32'(o.data));
        chk("hsync_o", 32'(hsync_o), 32'(o.hs));
        chk("vsync_o", 32'(vsync_o), 32'(o.vs));
        chk("valid", 32'(valid), 32'(o.val));
        chk("frame_start", 32'(frame_start), 32'(o.fs));
        cnt_fs += int'(frame_start);
        if (o.vid) begin
            chk("decode_b", 32'(dec(data[9:0])), 32'(o.rgb[7:0]));
            chk("decode_g", 32'(dec(data[19:10])), 32'(o.rgb[15:8]));
            chk("decode_r", 32'(dec(data[29:20])), 32'(o.rgb[23:16]));
            if (zero_phase) begin
                zs = (o.px % 2 == 0) ? 10'h100 : 10'h3FF;
                chk("black_pixel", 32'(data), 32'({3{zs}}));
            end
        end
    endtask

    initial begin
        int n;
        for (int c = 0; c < 3; c++) m_disp[c] = 0;
        m_run = 1'b0; m_pos = ENTRY; zero_phase = 1'b0;
        cnt_req = 0; cnt_fs = 0;

        repeat (3) step(1'b1, 1'b0, 24'($urandom));
        repeat (10) step(1'b0, 1'b0, 24'($urandom));

        zero_phase = 1'b1;
        repeat (130) step(1'b0, 1'b1, 24'h000000);
        zero_phase = 1'b0;

        n = 0;
        while (!(m_run && m_pos == 0) && n < 200) begin
            step(1'b0, 1'b1, 24'($urandom));
            n++;
        end
        chk("align_frame", 32'(n < 200), 32'd1);
        cnt_req = 0; cnt_fs = 0;
        for (int i = 0; i < 300; i++)
            step(1'b0, (m_pos == FT - 1) ? 1'b1 : 1'($urandom), 24'($urandom));
        chk("pix_req_per_3frames", 32'(cnt_req), 32'd24);
        chk("frame_start_per_3frames", 32'(cnt_fs), 32'd3);

        n = 0;
        while (!(m_run && m_pos % HT == 2 && m_pos / HT < VA) && n < 200) begin
            step(1'b0, 1'b1, 24'($urandom));
            n++;
        end
        chk("reach_mid_line", 32'(n < 200), 32'd1);
        repeat (2) step(1'b1, 1'b1, 24'($urandom));
        repeat (5) step(1'b0, 1'b0, 24'($urandom));
        repeat (60) step(1'b0, 1'b1, 24'($urandom));

        n = 0;
        while (m_run && n < 250) begin
            step(1'b0, 1'b0, 24'($urandom));
            n++;
        end
        chk("frame_drained", 32'(n < 250), 32'd1);
        repeat (5) step(1'b0, 1'b0, 24'($urandom));
        chk("idle_valid", 32'(valid), 32'd0);
        chk("idle_data", 32'(data), 32'(IDLE_W));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
